// File: rtl/i2s_tx.sv
// I2S master transmitter: derives scki/bclk/lrck from the system clock and serializes stereo
// samples taken through a single-entry valid/ready holding buffer.
module i2s_tx #(
    parameter int unsigned SAMPLE_W           = 24,
    parameter int unsigned SLOT_W             = 32,
    parameter int unsigned BCLK_HALF          = 4,
    parameter int unsigned REPEAT_ON_UNDERRUN = 1
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic [SAMPLE_W-1:0] left_i,
    input  logic [SAMPLE_W-1:0] right_i,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                scki,
    output logic                bclk,
    output logic                lrck,
    output logic                dout,
    output logic                frame_start,
    output logic                underrun
);

    localparam int unsigned DivW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int unsigned BcW  = $clog2(2 * SLOT_W);

    localparam logic [DivW-1:0] DivLast = DivW'(BCLK_HALF - 1);
    localparam logic [BcW-1:0]  BitLast = BcW'(2 * SLOT_W - 1);
    localparam logic [BcW-1:0]  SlotW   = BcW'(SLOT_W);

    typedef struct packed {
        logic [SAMPLE_W-1:0] l;
        logic [SAMPLE_W-1:0] r;
    } frame_t;

    logic            scki_q, scki_d;
    logic            bclk_q, bclk_d;
    logic            lrck_q, lrck_d;
    logic            dout_q, dout_d;
    logic            in_ready_q, in_ready_d;
    logic            frame_start_q, frame_start_d;
    logic            underrun_q, underrun_d;
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [BcW-1:0]  bit_cnt_q, bit_cnt_d;
    logic            hold_full_q, hold_full_d;
    frame_t          hold_q, hold_d;
    frame_t          active_q, active_d;
    frame_t          last_q, last_d;

    logic                tick;
    logic                fall_evt;
    logic                load;
    logic                accept;
    int unsigned         pos;
    logic [SAMPLE_W-1:0] word;
    logic [SAMPLE_W-1:0] word_sh;

    always_comb begin
        scki_d        = ~scki_q;
        div_cnt_d     = div_cnt_q;
        bclk_d        = bclk_q;
        lrck_d        = lrck_q;
        dout_d        = dout_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        bit_cnt_d     = bit_cnt_q;
        hold_full_d   = hold_full_q;
        hold_d        = hold_q;
        active_d      = active_q;
        last_d        = last_q;
        pos           = 0;
        word          = '0;
        word_sh       = '0;

        tick     = (div_cnt_q == DivLast);
        fall_evt = tick && bclk_q;
        load     = fall_evt && (bit_cnt_q == BitLast);
        accept   = in_valid && in_ready_q;

        div_cnt_d = tick ? '0 : div_cnt_q + DivW'(1);
        if (tick) begin
            bclk_d = ~bclk_q;
        end

        if (fall_evt) begin
            bit_cnt_d = (bit_cnt_q == BitLast) ? '0 : bit_cnt_q + BcW'(1);
            lrck_d    = (bit_cnt_d >= SlotW);
            pos       = lrck_d ? 32'(bit_cnt_d) - SLOT_W : 32'(bit_cnt_d);
            word      = lrck_d ? active_q.r : active_q.l;
            // Left-justify bit (SAMPLE_W-pos) into the MSB; position 0 is the I2S delay bit.
            word_sh   = word << (pos - 1);
            dout_d    = (pos >= 1 && pos <= SAMPLE_W) ? word_sh[SAMPLE_W-1] : 1'b0;
        end

        if (load) begin
            frame_start_d = 1'b1;
            if (hold_full_q) begin
                active_d    = hold_q;
                last_d      = hold_q;
                hold_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
                active_d   = (REPEAT_ON_UNDERRUN != 0) ? last_q : '0;
            end
        end

        // A write on the load edge refills the slot the load is vacating.
        if (accept) begin
            hold_d      = '{l: left_i, r: right_i};
            hold_full_d = 1'b1;
        end

        // Ready looks one edge ahead so a waiting pair is taken on the frame-load edge itself.
        in_ready_d = !hold_full_d ||
                     ((div_cnt_d == DivLast) && bclk_d && (bit_cnt_d == BitLast));
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            scki_q        <= 1'b0;
            bclk_q        <= 1'b0;
            lrck_q        <= 1'b0;
            dout_q        <= 1'b0;
            in_ready_q    <= 1'b1;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            div_cnt_q     <= '0;
            bit_cnt_q     <= BitLast;
            hold_full_q   <= 1'b0;
            hold_q        <= '0;
            active_q      <= '0;
            last_q        <= '0;
        end else begin
            scki_q        <= scki_d;
            bclk_q        <= bclk_d;
            lrck_q        <= lrck_d;
            dout_q        <= dout_d;
            in_ready_q    <= in_ready_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            div_cnt_q     <= div_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            hold_full_q   <= hold_full_d;
            hold_q        <= hold_d;
            active_q      <= active_d;
            last_q        <= last_d;
        end
    end

    assign scki        = scki_q;
    assign bclk        = bclk_q;
    assign lrck        = lrck_q;
    assign dout        = dout_q;
    assign in_ready    = in_ready_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: two instances (repeat and zero-fill underrun policy) driven in parallel and
// checked against edge-count arithmetic and a queue of the pairs the producer offered.
module tb_i2s_tx;

    localparam int unsigned SW = 24;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic [SW-1:0] left = '0;
    logic [SW-1:0] right = '0;
    logic          in_valid = 1'b0;

    logic in_ready, scki, bclk, lrck, dout, frame_start, underrun;
    logic in_ready0, scki0, bclk0, lrck0, dout0, frame_start0, underrun0;

    int unsigned cyc;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge nreset) begin
        if (!nreset) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    i2s_tx #(.SAMPLE_W(SW), .SLOT_W(32), .BCLK_HALF(4), .REPEAT_ON_UNDERRUN(1)) dut (
        .clk(clk), .nreset(nreset), .left_i(left), .right_i(right), .in_valid(in_valid),
        .in_ready(in_ready), .scki(scki), .bclk(bclk), .lrck(lrck), .dout(dout),
        .frame_start(frame_start), .underrun(underrun)
    );

    i2s_tx #(.SAMPLE_W(SW), .SLOT_W(32), .BCLK_HALF(4), .REPEAT_ON_UNDERRUN(0)) dut0 (
        .clk(clk), .nreset(nreset), .left_i(left), .right_i(right), .in_valid(in_valid),
        .in_ready(in_ready0), .scki(scki0), .bclk(bclk0), .lrck(lrck0), .dout(dout0),
        .frame_start(frame_start0), .underrun(underrun0)
    );

    task automatic do_reset();
        nreset = 1'b0;
        in_valid = 1'b0;
        left = '0;
        right = '0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic wait_frame(input int budget, output bit found, output logic ur1,
                              output logic ur0);
        found = 1'b0;
        ur1 = 1'b0;
        ur0 = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                found = 1'b1;
                ur1 = underrun;
                ur0 = underrun0;
            end
        end
    endtask

    // Collects one frame from bclk rising edges; lr_err >= 1000 means the frame never completed.
    task automatic capture_frame(output logic [SW-1:0] l1, output logic [SW-1:0] r1,
                                 output logic [SW-1:0] l0, output logic [SW-1:0] r0,
                                 output int pad_err, output int lr_err);
        logic pb;
        int   bits;
        int   p;
        l1 = '0; r1 = '0; l0 = '0; r0 = '0;
        pad_err = 0;
        lr_err = 0;
        bits = 0;
        pb = bclk;
        for (int g = 0; g < 1200 && bits < 64; g++) begin
            @(negedge clk);
            if (!pb && bclk) begin
                p = bits % 32;
                if (lrck !== (bits >= 32)) lr_err++;
                if (p >= 1 && p <= SW) begin
                    if (bits < 32) begin
                        l1 = {l1[SW-2:0], dout};
                        l0 = {l0[SW-2:0], dout0};
                    end else begin
                        r1 = {r1[SW-2:0], dout};
                        r0 = {r0[SW-2:0], dout0};
                    end
                end else if (dout !== 1'b0 || dout0 !== 1'b0) begin
                    pad_err++;
                end
                bits++;
            end
            pb = bclk;
        end
        if (bits < 64) lr_err += 1000;
    endtask

    task automatic test_reset();
        logic [SW-1:0] l1, r1, l0, r0;
        int pe, le;
        nreset = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({scki, bclk, lrck, dout, frame_start, underrun} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=000000",
                     {scki, bclk, lrck, dout, frame_start, underrun});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        nreset = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            checks++;
            if (bclk !== 1'((n / 4) % 2)) begin
                failures++;
                $display("FAIL reset_bclk edge=%0d got=%b exp=%b", n, bclk, 1'((n / 4) % 2));
            end
            checks++;
            if (scki !== 1'(n % 2)) begin
                failures++;
                $display("FAIL reset_scki edge=%0d got=%b exp=%b", n, scki, 1'(n % 2));
            end
            checks++;
            if (frame_start !== (n == 8) || underrun !== (n == 8)) begin
                failures++;
                $display("FAIL reset_first_frame edge=%0d got fs=%b ur=%b exp=%b", n,
                         frame_start, underrun, (n == 8));
            end
        end
        capture_frame(l1, r1, l0, r0, pe, le);
        checks++;
        if ({l1, r1, l0, r0} !== '0 || pe != 0 || le != 0) begin
            failures++;
            $display("FAIL reset_zero_frame got l=%h r=%h pad=%0d lr=%0d exp all zero",
                     l1, r1, pe, le);
        end
    endtask

    task automatic test_framing();
        logic [SW-1:0] el[4];
        logic [SW-1:0] er[4];
        logic [SW-1:0] l1, r1, l0, r0;
        logic u1, u0;
        bit found;
        int pe, le;
        el[0] = 24'hA5A5A5;
        er[0] = 24'h5A5A5A;
        for (int i = 1; i < 4; i++) begin
            el[i] = 24'($urandom);
            er[i] = 24'($urandom);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            left = el[i];
            right = er[i];
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            wait_frame(600, found, u1, u0);
            checks++;
            if (!found || u1 !== 1'b0 || u0 !== 1'b0) begin
                failures++;
                $display("FAIL framing_start frame=%0d got found=%0d ur=%b/%b exp 1 0/0", i,
                         found, u1, u0);
            end
            capture_frame(l1, r1, l0, r0, pe, le);
            checks++;
            if (l1 !== el[i] || r1 !== er[i] || l0 !== el[i] || r0 !== er[i]) begin
                failures++;
                $display("FAIL framing_words frame=%0d got %h/%h %h/%h exp %h/%h", i, l1, r1,
                         l0, r0, el[i], er[i]);
            end
            checks++;
            if (pe != 0 || le != 0) begin
                failures++;
                $display("FAIL framing_pad frame=%0d got pad=%0d lr=%0d exp 0 0", i, pe, le);
            end
        end
    endtask

    task automatic test_underrun();
        logic [SW-1:0] l1, r1, l0, r0;
        logic u1, u0;
        bit found;
        int pe, le;
        do_reset();
        left = 24'h123456;
        right = 24'h654321;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_frame(600, found, u1, u0);
        capture_frame(l1, r1, l0, r0, pe, le);
        checks++;
        if (!found || u1 !== 1'b0 || l1 !== 24'h123456 || r0 !== 24'h654321) begin
            failures++;
            $display("FAIL underrun_first got found=%0d ur=%b l=%h r0=%h exp 1 0 123456 654321",
                     found, u1, l1, r0);
        end
        wait_frame(600, found, u1, u0);
        checks++;
        if (!found || u1 !== 1'b1 || u0 !== 1'b1) begin
            failures++;
            $display("FAIL underrun_pulse got found=%0d ur=%b/%b exp 1 1/1", found, u1, u0);
        end
        @(negedge clk);
        checks++;
        if (underrun !== 1'b0 || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL underrun_one_clk got ur=%b fs=%b exp 0 0", underrun, frame_start);
        end
        capture_frame(l1, r1, l0, r0, pe, le);
        checks++;
        if (l1 !== 24'h123456 || r1 !== 24'h654321) begin
            failures++;
            $display("FAIL underrun_repeat got %h/%h exp 123456/654321", l1, r1);
        end
        checks++;
        if (l0 !== '0 || r0 !== '0 || pe != 0 || le != 0) begin
            failures++;
            $display("FAIL underrun_zero got %h/%h pad=%0d lr=%0d exp 0/0 0 0", l0, r0, pe, le);
        end
    endtask

    task automatic test_back_to_back();
        logic [SW-1:0] pl[3];
        logic [SW-1:0] pr[3];
        int unsigned acc[3];
        int unsigned exp_acc[3];
        exp_acc[0] = 1;
        exp_acc[1] = 8;
        exp_acc[2] = 520;
        for (int i = 0; i < 3; i++) begin
            pl[i] = {2'(i), 22'($urandom)};
            pr[i] = {2'(i), 22'($urandom)};
            acc[i] = 0;
        end
        do_reset();
        fork
            begin
                int k;
                logic rdy;
                k = 0;
                left = pl[0];
                right = pr[0];
                in_valid = 1'b1;
                for (int g = 0; g < 1500 && k < 3; g++) begin
                    rdy = in_ready;
                    @(negedge clk);
                    if (rdy) begin
                        acc[k] = cyc;
                        k++;
                        if (k == 1) begin
                            checks++;
                            if (in_ready !== 1'b0) begin
                                failures++;
                                $display("FAIL b2b_ready_drop got=%b exp=0", in_ready);
                            end
                        end
                        if (k < 3) begin
                            left = pl[k];
                            right = pr[k];
                        end else begin
                            in_valid = 1'b0;
                        end
                    end
                end
                in_valid = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (acc[i] != exp_acc[i]) begin
                        failures++;
                        $display("FAIL b2b_accept pair=%0d got edge=%0d exp edge=%0d", i,
                                 acc[i], exp_acc[i]);
                    end
                end
            end
            begin
                logic [SW-1:0] l1, r1, l0, r0;
                logic u1, u0;
                bit found;
                int pe, le;
                for (int f = 0; f < 3; f++) begin
                    wait_frame(600, found, u1, u0);
                    capture_frame(l1, r1, l0, r0, pe, le);
                    checks++;
                    if (!found || u1 !== 1'b0 || l1 !== pl[f] || r1 !== pr[f] || le != 0) begin
                        failures++;
                        $display("FAIL b2b_frame f=%0d got found=%0d ur=%b %h/%h exp 1 0 %h/%h",
                                 f, found, u1, l1, r1, pl[f], pr[f]);
                    end
                end
            end
        join
    endtask

    task automatic test_stream();
        logic [SW-1:0] sl[6];
        logic [SW-1:0] sr[6];
        for (int i = 0; i < 6; i++) begin
            sl[i] = 24'($urandom);
            sr[i] = 24'($urandom);
        end
        do_reset();
        fork
            begin
                int nacc;
                bit done;
                logic rdy;
                nacc = 0;
                for (int k = 0; k < 6; k++) begin
                    int gap;
                    gap = (k == 0) ? 0 : int'($urandom_range(0, 100));
                    repeat (gap) @(negedge clk);
                    left = sl[k];
                    right = sr[k];
                    in_valid = 1'b1;
                    done = 1'b0;
                    for (int g = 0; g < 1200 && !done; g++) begin
                        rdy = in_ready;
                        @(negedge clk);
                        if (rdy) done = 1'b1;
                    end
                    in_valid = 1'b0;
                    if (done) nacc++;
                end
                checks++;
                if (nacc != 6) begin
                    failures++;
                    $display("FAIL stream_accepts got=%0d exp=6", nacc);
                end
            end
            begin
                logic [SW-1:0] l1, r1, l0, r0;
                logic u1, u0;
                bit found;
                int pe, le;
                for (int f = 0; f < 6; f++) begin
                    wait_frame(700, found, u1, u0);
                    capture_frame(l1, r1, l0, r0, pe, le);
                    checks++;
                    if (!found || u1 !== 1'b0 || l1 !== sl[f] || r1 !== sr[f] ||
                        l0 !== sl[f] || pe != 0 || le != 0) begin
                        failures++;
                        $display("FAIL stream_frame f=%0d got ur=%b %h/%h exp 0 %h/%h", f, u1,
                                 l1, r1, sl[f], sr[f]);
                    end
                end
            end
        join
    endtask

    task automatic test_reset_mid();
        logic [SW-1:0] l1, r1, l0, r0;
        int pe, le;
        do_reset();
        left = 24'h111111;
        right = 24'h222222;
        in_valid = 1'b1;
        @(negedge clk);
        left = 24'hABCDEF;
        right = 24'hFEDCBA;
        for (int g = 0; g < 20 && cyc != 8; g++) @(negedge clk);
        in_valid = 1'b0;
        for (int g = 0; g < 400 && cyc != 328; g++) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || lrck !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre got ready=%b lrck=%b exp 0 1", in_ready, lrck);
        end
        #2;
        nreset = 1'b0;
        #1;
        checks++;
        if ({scki, bclk, lrck, dout, frame_start, underrun} !== 6'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_async got=%b rdy=%b exp=000000 1",
                     {scki, bclk, lrck, dout, frame_start, underrun}, in_ready);
        end
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            checks++;
            if (bclk !== 1'((n / 4) % 2) || frame_start !== (n == 8) ||
                underrun !== (n == 8)) begin
                failures++;
                $display("FAIL midrst_timing edge=%0d got bclk=%b fs=%b ur=%b", n, bclk,
                         frame_start, underrun);
            end
        end
        capture_frame(l1, r1, l0, r0, pe, le);
        checks++;
        if ({l1, r1} !== '0 || le != 0) begin
            failures++;
            $display("FAIL midrst_cleared got %h/%h lr=%0d exp 0/0 0", l1, r1, le);
        end
    endtask

    task automatic test_clock_ratio();
        logic ps, pb, plr;
        int   viol;
        bit   found;
        do_reset();
        viol = 0;
        found = 1'b0;
        plr = lrck;
        for (int g = 0; g < 700 && !found; g++) begin
            @(negedge clk);
            if (!plr && lrck) found = 1'b1;
            plr = lrck;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL ratio_lrck_start got no lrck rise exp one");
        end
        ps = scki;
        pb = bclk;
        for (int per = 0; per < 10; per++) begin
            int ns, nb;
            bit nxt;
            ns = 0;
            nb = 0;
            nxt = 1'b0;
            for (int g = 0; g < 700 && !nxt; g++) begin
                @(negedge clk);
                if (!ps && scki) ns++;
                if (!pb && bclk) nb++;
                if (lrck !== plr && !(pb && !bclk)) viol++;
                if (!plr && lrck) nxt = 1'b1;
                ps = scki;
                pb = bclk;
                plr = lrck;
            end
            checks++;
            if (ns != 256 || nb != 64) begin
                failures++;
                $display("FAIL ratio_counts period=%0d got scki=%0d bclk=%0d exp 256 64", per,
                         ns, nb);
            end
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL ratio_lrck_edge got violations=%0d exp 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_framing();
        test_underrun();
        test_back_to_back();
        test_stream();
        test_reset_mid();
        test_clock_ratio();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
